// File: rtl/tri_cmd_sched_if.sv
// Host command / triangle FIFO / rasterizer pacing bundle for tri_cmd_sched.
// master: the host, FIFO and rasterizer side; slave: the scheduler.
interface tri_cmd_sched_if #(
    parameter int BAND_W = 7
);
    logic              tri_valid;
    logic [479:0]      tri_data;
    logic              tri_last;
    logic              end_valid;
    logic              tri_ready;
    logic              fifo_full;
    logic [239:0]      fifo_wrdata;
    logic              fifo_push;
    logic              draw_next;
    logic              frame_done;
    logic [BAND_W-1:0] bands_left;

    modport master (
        output tri_valid, tri_data, tri_last, end_valid, fifo_full, draw_next,
        input  tri_ready, fifo_wrdata, fifo_push, frame_done, bands_left
    );

    modport slave (
        input  tri_valid, tri_data, tri_last, end_valid, fifo_full, draw_next,
        output tri_ready, fifo_wrdata, fifo_push, frame_done, bands_left
    );
endinterface

// File: rtl/tri_cmd_sched.sv
// Triangle command scheduler: single writer of the rasterizer triangle FIFO.
// Pushes each 480-bit triangle as two 240-bit words, then closes the frame with
// NUM_BANDS-1 end-of-band records and one end-of-frame record, each record
// paced by the rasterizer's draw_next pulse.
//
// state | meaning
// IDLE  | waiting: host triangle/end request (FILL) or next marker (MARK)
// TRI1  | pushing triangle upper word [479:240]
// TRI2  | pushing triangle lower word [239:0]
// EFB1  | pushing end-of-band marker word
// EFB2  | pushing end-of-band trailer word
// EF1   | pushing end-of-frame marker word
// EF2   | pushing end-of-frame trailer word, frame_done pulse
module tri_cmd_sched #(
    parameter int NUM_BANDS = 80,
    parameter int BAND_W    = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    tri_cmd_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRI1, S_TRI2, S_EFB1, S_EFB2, S_EF1, S_EF2
    } state_t;

    typedef enum logic {
        PH_FILL, PH_MARK
    } phase_t;

    localparam logic [BAND_W-1:0] BANDS_INIT = BAND_W'(NUM_BANDS - 1);
    localparam logic [239:0]      EFB_WORD   = 240'h80;
    localparam logic [239:0]      EF_WORD    = 240'h40;

    state_t            state;
    phase_t            phase;
    logic              draw_rdy;
    logic [BAND_W-1:0] bands_left;
    logic [239:0]      tri_lo;
    logic              last_q;
    logic              push_q;
    logic [239:0]      wrdata_q;
    logic              frame_done_q;

    logic tri_ready_c;
    logic accept_tri;
    logic accept_end;
    logic mark_go;

    assign tri_ready_c = (state == S_IDLE) && (phase == PH_FILL) && !bus.fifo_full;
    assign accept_tri  = bus.tri_valid && tri_ready_c;
    // A simultaneous triangle wins; the host keeps end_valid up until a later IDLE.
    assign accept_end  = bus.end_valid && tri_ready_c && !bus.tri_valid;
    assign mark_go     = (state == S_IDLE) && (phase == PH_MARK) && !bus.fifo_full && draw_rdy;

    assign bus.tri_ready   = tri_ready_c;
    assign bus.fifo_push   = push_q;
    assign bus.fifo_wrdata = wrdata_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.bands_left  = bands_left;

    // Main sequencer: state, phase, band count and registered FIFO write outputs.
    // Outputs are set on entry to a push state so they line up with that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            phase        <= PH_FILL;
            bands_left   <= '0;
            tri_lo       <= '0;
            last_q       <= 1'b0;
            push_q       <= 1'b0;
            wrdata_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            wrdata_q     <= '0;
            frame_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_tri) begin
                        tri_lo   <= bus.tri_data[239:0];
                        last_q   <= bus.tri_last;
                        state    <= S_TRI1;
                        push_q   <= 1'b1;
                        wrdata_q <= bus.tri_data[479:240];
                    end else if (accept_end) begin
                        phase      <= PH_MARK;
                        bands_left <= BANDS_INIT;
                    end else if (mark_go) begin
                        push_q <= 1'b1;
                        if (bands_left != '0) begin
                            state    <= S_EFB1;
                            wrdata_q <= EFB_WORD;
                        end else begin
                            state    <= S_EF1;
                            wrdata_q <= EF_WORD;
                        end
                    end
                end
                S_TRI1: begin
                    state    <= S_TRI2;
                    push_q   <= 1'b1;
                    wrdata_q <= tri_lo;
                end
                S_TRI2: begin
                    state <= S_IDLE;
                    if (last_q) begin
                        phase      <= PH_MARK;
                        bands_left <= BANDS_INIT;
                    end
                end
                S_EFB1: begin
                    bands_left <= bands_left - 1'b1;
                    state      <= S_EFB2;
                    push_q     <= 1'b1;
                end
                S_EFB2: begin
                    state <= S_IDLE;
                end
                S_EF1: begin
                    state        <= S_EF2;
                    push_q       <= 1'b1;
                    frame_done_q <= 1'b1;
                end
                S_EF2: begin
                    phase <= PH_FILL;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Marker pacing flag: a draw_next pulse is remembered wherever it lands and
    // beats the clear issued by a marker's first word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            draw_rdy <= 1'b1;
        end else if (bus.draw_next) begin
            draw_rdy <= 1'b1;
        end else if (state == S_EFB1 || state == S_EF1) begin
            draw_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tri_cmd_sched.sv
// Self-checking bench for tri_cmd_sched: an ordered queue of expected FIFO
// words built from host actions checks every push; scenario tasks check timing.
module tb_tri_cmd_sched;

    localparam int NB = 80;
    localparam logic [239:0] EFB_W = 240'h80;
    localparam logic [239:0] EF_W  = 240'h40;

    logic clk;
    logic rst_n;

    tri_cmd_sched_if #(.BAND_W(7)) bus ();
    tri_cmd_sched_if #(.BAND_W(1)) bus1 ();

    tri_cmd_sched #(.NUM_BANDS(NB), .BAND_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    tri_cmd_sched #(.NUM_BANDS(1), .BAND_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int errors = 0;
    int checks = 0;
    logic [239:0] exp_q[$];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every push on the main DUT must be the next expected word.
    always @(negedge clk) begin
        if (rst_n && bus.fifo_push === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected: got push of %h, want no push", bus.fifo_wrdata);
            end else begin
                logic [239:0] w;
                w = exp_q.pop_front();
                if (bus.fifo_wrdata !== w) begin
                    errors++;
                    $display("FAIL push_word: got %h want %h", bus.fifo_wrdata, w);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tri_valid = 1'b0; bus.tri_data = '0; bus.tri_last = 1'b0;
        bus.end_valid = 1'b0; bus.draw_next = 1'b0; bus.fifo_full = 1'b0;
        bus1.tri_valid = 1'b0; bus1.tri_data = '0; bus1.tri_last = 1'b0;
        bus1.end_valid = 1'b0; bus1.draw_next = 1'b0; bus1.fifo_full = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    function automatic logic [479:0] rand_tri();
        logic [479:0] a;
        for (int k = 0; k < 15; k++) a[k*32 +: 32] = $urandom();
        return a;
    endfunction

    // Expected FIFO content of one triangle and of a full frame close.
    function automatic void exp_tri(input logic [479:0] a);
        exp_q.push_back(a[479:240]);
        exp_q.push_back(a[239:0]);
    endfunction

    function automatic void exp_frame(input int nbands);
        for (int i = 0; i < nbands - 1; i++) begin
            exp_q.push_back(EFB_W);
            exp_q.push_back('0);
        end
        exp_q.push_back(EF_W);
        exp_q.push_back('0);
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", bus.fifo_push); end
        checks++; if (bus.fifo_wrdata !== 240'h0) begin errors++; $display("FAIL reset_wrdata: got %h want 0", bus.fifo_wrdata); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        checks++; if (bus.bands_left !== 7'd0) begin errors++; $display("FAIL reset_bands_left: got %0d want 0", bus.bands_left); end
        checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_empty: got %b want 1", bus.tri_ready); end
        bus.fifo_full = 1'b1;
        #1;
        checks++; if (bus.tri_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_full: got %b want 0", bus.tri_ready); end
        bus.fifo_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_tri();
        logic [479:0] a;
        a = rand_tri();
        bus.tri_valid = 1'b1; bus.tri_data = a; bus.tri_last = 1'b0;
        #1;
        checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.tri_ready); end
        exp_tri(a);
        cyc();
        checks++; if (bus.fifo_push !== 1'b1 || bus.tri_ready !== 1'b0) begin errors++; $display("FAIL single_tri1: push %b ready %b want 1 0", bus.fifo_push, bus.tri_ready); end
        cyc();
        bus.tri_valid = 1'b0;
        checks++; if (bus.fifo_push !== 1'b1 || bus.tri_ready !== 1'b0) begin errors++; $display("FAIL single_tri2: push %b ready %b want 1 0", bus.fifo_push, bus.tri_ready); end
        cyc();
        checks++; if (bus.fifo_push !== 1'b0 || bus.tri_ready !== 1'b1) begin errors++; $display("FAIL single_idle: push %b ready %b want 0 1", bus.fifo_push, bus.tri_ready); end
    endtask

    // Back-to-back and gapped triangles with random FIFO backpressure.
    task automatic test_random_tris();
        for (int it = 0; it < 24; it++) begin
            logic [479:0] a;
            logic full, valid;
            a = rand_tri();
            full = ($urandom_range(3) == 0);
            valid = ($urandom_range(3) != 0);
            bus.tri_valid = valid; bus.tri_data = a; bus.fifo_full = full;
            #1;
            checks++; if (bus.tri_ready !== !full) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", it, bus.tri_ready, !full); end
            if (valid && !full) begin
                exp_tri(a);
                cyc();
                bus.tri_valid = 1'b0; bus.fifo_full = 1'b0;
                cyc();
                cyc();
            end else begin
                cyc();
                checks++; if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL rand_nopush[%0d]: got %b want 0", it, bus.fifo_push); end
            end
        end
        bus.tri_valid = 1'b0; bus.fifo_full = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [479:0] a;
        a = rand_tri();
        bus.fifo_full = 1'b1; bus.tri_valid = 1'b1; bus.tri_data = a;
        #1;
        checks++; if (bus.tri_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", bus.tri_ready); end
        cyc();
        checks++; if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL bp_nopush: got %b want 0", bus.fifo_push); end
        bus.fifo_full = 1'b0;
        #1;
        exp_tri(a);
        cyc();
        bus.tri_valid = 1'b0;
        bus.fifo_full = 1'b1;
        cyc();
        checks++; if (bus.fifo_push !== 1'b1) begin errors++; $display("FAIL bp_word1: push %b want 1", bus.fifo_push); end
        cyc();
        checks++; if (bus.tri_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after: got %b want 0", bus.tri_ready); end
        bus.fifo_full = 1'b0;
        cyc();
    endtask

    task automatic test_priority();
        logic [479:0] a;
        a = rand_tri();
        bus.tri_valid = 1'b1; bus.end_valid = 1'b1; bus.tri_data = a;
        #1;
        checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got %b want 1", bus.tri_ready); end
        exp_tri(a);
        cyc();
        bus.tri_valid = 1'b0;
        checks++; if (bus.bands_left !== 7'd0) begin errors++; $display("FAIL prio_tri_first: bands_left %0d want 0", bus.bands_left); end
        cyc();
        cyc();
        checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL prio_end_ready: got %b want 1", bus.tri_ready); end
        exp_frame(NB);
        cyc();
        bus.end_valid = 1'b0;
        checks++; if (bus.bands_left !== 7'(NB - 1) || bus.tri_ready !== 1'b0) begin errors++; $display("FAIL prio_mark: bands_left %0d ready %b want %0d 0", bus.bands_left, bus.tri_ready, NB - 1); end
    endtask

    task automatic test_frame_close();
        logic [479:0] a;
        int n;
        do_reset();
        a = rand_tri();
        bus.tri_valid = 1'b1; bus.tri_data = a; bus.tri_last = 1'b1;
        #1;
        exp_tri(a);
        exp_frame(NB);
        cyc();
        bus.tri_valid = 1'b0; bus.tri_last = 1'b0;
        cyc();
        cyc();
        checks++; if (bus.bands_left !== 7'(NB - 1) || bus.tri_ready !== 1'b0) begin errors++; $display("FAIL fc_enter_mark: bands_left %0d ready %b want %0d 0", bus.bands_left, bus.tri_ready, NB - 1); end
        for (int i = 0; i < NB - 1; i++) begin
            n = 0;
            while (bus.fifo_push !== 1'b1 && n < 20) begin cyc(); n++; end
            checks++; if (n >= 20) begin errors++; $display("FAIL fc_efb_timeout[%0d]: no push within 20 cycles", i); end
            checks++; if (bus.bands_left !== 7'(NB - 1 - i) || bus.tri_ready !== 1'b0) begin errors++; $display("FAIL fc_efb1[%0d]: bands_left %0d ready %b want %0d 0", i, bus.bands_left, bus.tri_ready, NB - 1 - i); end
            cyc();
            checks++; if (bus.bands_left !== 7'(NB - 2 - i) || bus.frame_done !== 1'b0) begin errors++; $display("FAIL fc_efb2[%0d]: bands_left %0d frame_done %b want %0d 0", i, bus.bands_left, bus.frame_done, NB - 2 - i); end
            bus.draw_next = 1'b1;
            cyc();
            bus.draw_next = 1'b0;
        end
        n = 0;
        while (bus.fifo_push !== 1'b1 && n < 20) begin cyc(); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL fc_ef_timeout: no push within 20 cycles"); end
        checks++; if (bus.fifo_wrdata !== EF_W || bus.frame_done !== 1'b0) begin errors++; $display("FAIL fc_ef1: wrdata %h frame_done %b want 40 0", bus.fifo_wrdata, bus.frame_done); end
        cyc();
        checks++; if (bus.frame_done !== 1'b1 || bus.fifo_push !== 1'b1) begin errors++; $display("FAIL fc_ef2: frame_done %b push %b want 1 1", bus.frame_done, bus.fifo_push); end
        cyc();
        checks++; if (bus.frame_done !== 1'b0 || bus.tri_ready !== 1'b1) begin errors++; $display("FAIL fc_after: frame_done %b ready %b want 0 1", bus.frame_done, bus.tri_ready); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fc_drain: %0d words outstanding want 0", exp_q.size()); end
    endtask

    // Empty frame via end_valid, then draw_next pacing; ends inside an EFB1 cycle.
    task automatic test_pacing();
        logic quiet;
        do_reset();
        bus.end_valid = 1'b1;
        #1;
        checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL pace_end_ready: got %b want 1", bus.tri_ready); end
        exp_frame(NB);
        cyc();
        bus.end_valid = 1'b0;
        checks++; if (bus.bands_left !== 7'(NB - 1) || bus.fifo_push !== 1'b0) begin errors++; $display("FAIL pace_mark: bands_left %0d push %b want %0d 0", bus.bands_left, bus.fifo_push, NB - 1); end
        cyc();
        checks++; if (bus.fifo_push !== 1'b1 || bus.fifo_wrdata !== EFB_W) begin errors++; $display("FAIL pace_first_efb: push %b wrdata %h want 1 80", bus.fifo_push, bus.fifo_wrdata); end
        cyc();
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (bus.fifo_push !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL pace_hold: got a push without draw_next, want none"); end
        bus.draw_next = 1'b1;
        cyc();
        bus.draw_next = 1'b0;
        checks++; if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL pace_rdy_cycle: push %b want 0", bus.fifo_push); end
        cyc();
        checks++; if (bus.fifo_push !== 1'b1 || bus.fifo_wrdata !== EFB_W) begin errors++; $display("FAIL pace_second_efb: push %b wrdata %h want 1 80", bus.fifo_push, bus.fifo_wrdata); end
        bus.draw_next = 1'b1;
        cyc();
        bus.draw_next = 1'b0;
        cyc();
        cyc();
        checks++; if (bus.fifo_push !== 1'b1 || bus.fifo_wrdata !== EFB_W) begin errors++; $display("FAIL pace_set_wins: push %b wrdata %h want 1 80", bus.fifo_push, bus.fifo_wrdata); end
    endtask

    task automatic test_reset_mid();
        checks++; if (bus.fifo_push !== 1'b1) begin errors++; $display("FAIL rmid_in_efb1: push %b want 1", bus.fifo_push); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fifo_push !== 1'b0 || bus.fifo_wrdata !== 240'h0) begin errors++; $display("FAIL rmid_push: push %b wrdata %h want 0 0", bus.fifo_push, bus.fifo_wrdata); end
        checks++; if (bus.tri_ready !== 1'b1 || bus.bands_left !== 7'd0) begin errors++; $display("FAIL rmid_state: ready %b bands_left %0d want 1 0", bus.tri_ready, bus.bands_left); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        bus.end_valid = 1'b1;
        #1;
        exp_frame(NB);
        cyc();
        bus.end_valid = 1'b0;
        cyc();
        checks++; if (bus.fifo_push !== 1'b1 || bus.fifo_wrdata !== EFB_W) begin errors++; $display("FAIL rmid_draw_rdy: push %b wrdata %h want 1 80", bus.fifo_push, bus.fifo_wrdata); end
    endtask

    task automatic test_num_bands_one();
        do_reset();
        bus1.end_valid = 1'b1;
        #1;
        checks++; if (bus1.tri_ready !== 1'b1) begin errors++; $display("FAIL nb1_ready: got %b want 1", bus1.tri_ready); end
        cyc();
        bus1.end_valid = 1'b0;
        checks++; if (bus1.bands_left !== 1'b0 || bus1.fifo_push !== 1'b0 || bus1.tri_ready !== 1'b0) begin errors++; $display("FAIL nb1_mark: bands_left %0d push %b ready %b want 0 0 0", bus1.bands_left, bus1.fifo_push, bus1.tri_ready); end
        cyc();
        checks++; if (bus1.fifo_push !== 1'b1 || bus1.fifo_wrdata !== EF_W) begin errors++; $display("FAIL nb1_ef1: push %b wrdata %h want 1 40", bus1.fifo_push, bus1.fifo_wrdata); end
        cyc();
        checks++; if (bus1.fifo_push !== 1'b1 || bus1.fifo_wrdata !== 240'h0 || bus1.frame_done !== 1'b1) begin errors++; $display("FAIL nb1_ef2: push %b wrdata %h frame_done %b want 1 0 1", bus1.fifo_push, bus1.fifo_wrdata, bus1.frame_done); end
        cyc();
        checks++; if (bus1.frame_done !== 1'b0 || bus1.tri_ready !== 1'b1) begin errors++; $display("FAIL nb1_after: frame_done %b ready %b want 0 1", bus1.frame_done, bus1.tri_ready); end
    endtask

    // Scenario sequence.
    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_single_tri();
        test_random_tris();
        test_backpressure();
        test_priority();
        test_frame_close();
        test_pacing();
        test_reset_mid();
        test_num_bands_one();
        cyc();
        cyc();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain: %0d words outstanding want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
